group_add_tree: RTL and testbench
=================================

Name: group_add_tree

Overview:
- Parametrised pipelined signed adder tree that sums GROUP_NB numbers into one result.
- Next generation of the fixed 3-input filter group adder: any group size, valid/ready flow control with stall, optional saturating arithmetic and a per-result overflow flag.
- Sits between the filter multiply stage and the downstream accumulator/output stream.

Parameters:
- GROUP_NB, 4: number of inputs to sum; legal range 2..32; an illegal value triggers $display error + $finish at elaboration.
- NUM_WIDTH, 16: width of every input and of the output, two's complement.
- SATURATE, 1: 1 = each pairwise add clamps to [-2^(W-1), 2^(W-1)-1]; 0 = modular wrap.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- up_data  input  NUM_WIDTH*GROUP_NB  packed inputs; element k at [k*NUM_WIDTH +: NUM_WIDTH].
- up_val  input  1  up_data valid.
- up_rdy  output  1  block can accept up_data this cycle.
- dn_data  output  NUM_WIDTH  sum.
- dn_sat  output  1  overflow occurred in any adder contributing to dn_data.
- dn_val  output  1  dn_data/dn_sat valid.
- dn_rdy  input  1  downstream accepts.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- LEVELS = clog2(GROUP_NB); LATENCY = LEVELS + 1 (input register + one register per tree level; the last level register drives dn_*).
- Global enable en = ~dn_val | dn_rdy; up_rdy = en (combinational, no registered path from up_val).
- Transfers:
  - Input transfer when up_val & up_rdy.
  - Output transfer when dn_val & dn_rdy.
  - While en = 0 every pipeline register (data, sat, valid) holds.
- Each stage carries a valid bit. On en, the valid bit shifts in from the previous stage; the input stage valid takes up_val & up_rdy. A bubble (valid = 0) advances like data; bubbles are not collapsed.
- Tree pairing, level l:
  - Element 2j of level l-1 is added to element 2j+1 to give element j.
  - An odd leftover last element passes through unchanged, with its sat bit carried.
- Pairwise add:
  - Sign-extend both operands to NUM_WIDTH+1 and sum.
  - Overflow when bits [W] and [W-1] of the sum differ.
  - SATURATE=1: result clamps to 0x7F..F (positive overflow) or 0x80..0 (negative overflow).
  - SATURATE=0: result is the low NUM_WIDTH bits.
  - Saturation is per adder, not on the final sum (intermediate clamp can differ from the true sum; this is intended).
- Sat bit: OR of the overflow flags of all adders on the path plus the incoming sat bits. dn_sat reports overflow in both modes.
- Reset: all valid bits, dn_data, dn_sat cleared to 0 immediately (async). Internal data registers also reset to 0. up_rdy = 1 out of reset.
- Reset mid-operation: in-flight results are discarded; no output after release until new input has traversed LATENCY cycles.
- Simultaneous output transfer and new input with a full pipe: allowed, full throughput of 1 result/cycle.
- dn_data/dn_sat stable while dn_val & ~dn_rdy.

Decomposition:
- Shared include (group_defs.vh): clog2 constant function, SAT_MAX/SAT_MIN macros parametrised by width.
- Sub-module group_add_sat: registered pairwise saturating adder with enable, inputs a/b/sat_a/sat_b, outputs sum/sat, parameters NUM_WIDTH and SATURATE.
- Tree levels and pass-through are built with generate loops in group_add_tree; the valid chain stays in the top module.

Test Plan:
- GROUP_NB=3, W=16, dn_rdy=1: inputs 1,2,3 -> dn_data=6, dn_sat=0, dn_val exactly 3 cycles after input transfer.
- GROUP_NB=3, SATURATE=1: 0x7000,0x7000,0x0001 -> dn_data=0x7FFF, dn_sat=1. With SATURATE=0 -> dn_data=0xE001, dn_sat=1.
- GROUP_NB=4, SATURATE=1: 0x8000,0xFFFF,0x0000,0x0000 -> dn_data=0x8000, dn_sat=1. Inputs 0xFFFF x4 -> 0xFFFC, dn_sat=0.
- GROUP_NB=5: inputs 1..5 -> 15 after LATENCY=4 (odd pass-through at two levels).
- Back-to-back stream of 8 vectors; dn_rdy low for 5 cycles mid-stream -> up_rdy low during the stall, all 8 sums delivered in order, none lost or duplicated, dn_data stable while stalled.
- rst_n pulsed low with 2 results in flight -> dn_val=0, dn_data=0 asynchronously. No stale output after release; the next input yields a correct result after LATENCY cycles.

Source files
------------

// File: rtl/group_add_tree_pkg.sv
// Shared elaboration-time helpers for the group adder tree: level sizing and
// the flat node-index layout used to wire consecutive tree levels together.
package group_add_tree_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pow;
    res = 0;
    pow = 1;
    while (pow < value) begin
      pow = pow << 1;
      res = res + 1;
    end
    return res;
  endfunction

  // Number of elements on tree level lvl (level 0 = registered inputs).
  function automatic int unsigned lvl_count(input int unsigned group_nb,
                                            input int unsigned lvl);
    return (group_nb + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  // Index of the first element of level lvl in the flat node vector.
  function automatic int unsigned lvl_base(input int unsigned group_nb,
                                           input int unsigned lvl);
    int unsigned base;
    base = 0;
    for (int unsigned m = 0; m < lvl; m++) begin
      base = base + lvl_count(group_nb, m);
    end
    return base;
  endfunction

endpackage

// File: rtl/group_add_tree_sat.sv
// Registered pairwise signed adder with optional clamping and a sticky
// overflow flag that ORs in the overflow history of both operands.
module group_add_sat #(
  parameter int NUM_WIDTH = 16,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_WIDTH-1:0] a,
  input  logic [NUM_WIDTH-1:0] b,
  input  logic                 sat_a,
  input  logic                 sat_b,
  output logic [NUM_WIDTH-1:0] sum,
  output logic                 sat
);

  localparam logic [NUM_WIDTH-1:0] SAT_MAX = {1'b0, {(NUM_WIDTH-1){1'b1}}};
  localparam logic [NUM_WIDTH-1:0] SAT_MIN = {1'b1, {(NUM_WIDTH-1){1'b0}}};

  logic [NUM_WIDTH:0]   wide;
  logic                 ovf;
  logic [NUM_WIDTH-1:0] res;

  // One-bit-wider sum; overflow shows as disagreement of the top two bits.
  always_comb begin
    wide = {a[NUM_WIDTH-1], a} + {b[NUM_WIDTH-1], b};
    ovf  = wide[NUM_WIDTH] ^ wide[NUM_WIDTH-1];
    res  = wide[NUM_WIDTH-1:0];
    if (SATURATE && ovf) begin
      res = wide[NUM_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // Result register, held while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      sat <= 1'b0;
    end else if (en) begin
      sum <= res;
      sat <= ovf | sat_a | sat_b;
    end
  end

endmodule

// File: rtl/group_add_tree.sv
// Pipelined signed adder tree: registers GROUP_NB inputs, then halves the
// element count each level until one sum remains. Whole-pipe stall via en.
module group_add_tree
  import group_add_tree_pkg::*;
#(
  parameter int GROUP_NB  = 4,
  parameter int NUM_WIDTH = 16,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_WIDTH*GROUP_NB-1:0] up_data,
  input  logic                          up_val,
  output logic                          up_rdy,
  output logic [NUM_WIDTH-1:0]          dn_data,
  output logic                          dn_sat,
  output logic                          dn_val,
  input  logic                          dn_rdy
);

  localparam int unsigned LEVELS = clog2(GROUP_NB);
  localparam int unsigned TOTAL  = lvl_base(GROUP_NB, LEVELS + 1);

  if (GROUP_NB < 2 || GROUP_NB > 32) begin : g_bad_group_nb
    $fatal(1, "group_add_tree: GROUP_NB=%0d outside legal range 2..32", GROUP_NB);
  end

  // All levels live in one flat vector so each level addresses the previous
  // one through lvl_base(); every slot has exactly one driver.
  logic [TOTAL*NUM_WIDTH-1:0]    node_data;
  logic [TOTAL-1:0]              node_sat;
  logic [NUM_WIDTH*GROUP_NB-1:0] in_q;
  logic [LEVELS:0]               vld;
  logic                          en;

  assign en     = ~vld[LEVELS] | dn_rdy;
  assign up_rdy = en;

  // Input register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
    end else if (en) begin
      in_q <= up_data;
    end
  end

  assign node_data[NUM_WIDTH*GROUP_NB-1:0] = in_q;
  assign node_sat[GROUP_NB-1:0]            = '0;

  // Valid chain: bubbles advance with the data and are never collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[LEVELS-1:0], up_val & up_rdy};
    end
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned NPREV = lvl_count(GROUP_NB, l - 1);
    localparam int unsigned PBASE = lvl_base(GROUP_NB, l - 1);
    localparam int unsigned CBASE = lvl_base(GROUP_NB, l);

    for (genvar j = 0; j < NPREV / 2; j++) begin : g_add
      group_add_sat #(
        .NUM_WIDTH (NUM_WIDTH),
        .SATURATE  (SATURATE)
      ) u_add (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (node_data[(PBASE + 2*j)     * NUM_WIDTH +: NUM_WIDTH]),
        .b     (node_data[(PBASE + 2*j + 1) * NUM_WIDTH +: NUM_WIDTH]),
        .sat_a (node_sat[PBASE + 2*j]),
        .sat_b (node_sat[PBASE + 2*j + 1]),
        .sum   (node_data[(CBASE + j) * NUM_WIDTH +: NUM_WIDTH]),
        .sat   (node_sat[CBASE + j])
      );
    end

    if (NPREV % 2 == 1) begin : g_pass
      logic [NUM_WIDTH-1:0] pass_data;
      logic                 pass_sat;

      // Odd leftover element is delayed one level unchanged, sat bit kept.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pass_data <= '0;
          pass_sat  <= 1'b0;
        end else if (en) begin
          pass_data <= node_data[(PBASE + NPREV - 1) * NUM_WIDTH +: NUM_WIDTH];
          pass_sat  <= node_sat[PBASE + NPREV - 1];
        end
      end

      assign node_data[(CBASE + NPREV/2) * NUM_WIDTH +: NUM_WIDTH] = pass_data;
      assign node_sat[CBASE + NPREV/2]                             = pass_sat;
    end
  end

  assign dn_data = node_data[(TOTAL-1) * NUM_WIDTH +: NUM_WIDTH];
  assign dn_sat  = node_sat[TOTAL-1];
  assign dn_val  = vld[LEVELS];

endmodule

// File: tb/tb_group_add_tree.sv
// Scoreboard bench: four group_add_tree configurations run in lockstep on the
// same stimulus; a monitor compares every delivered sum against a queue of
// expectations computed from the pairwise-add rules with plain integers.
module tb_group_add_tree;

  localparam int W    = 16;
  localparam int ND   = 4;
  localparam int MAXG = 5;

  function automatic int g_of(input int i);
    case (i)
      0: return 3;
      1: return 3;
      2: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic bit s_of(input int i);
    return (i == 1) ? 1'b0 : 1'b1;
  endfunction

  // Expected latency: input register plus ceil(log2(G)) tree levels.
  function automatic int lat_of(input int i);
    int lv;
    lv = 0;
    while ((1 << lv) < g_of(i)) lv++;
    return lv + 1;
  endfunction

  typedef struct {
    logic [W-1:0] d;
    logic         s;
    int           cyc;
    bit           strict;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dn_rdy;
  logic              up_val;
  logic [MAXG*W-1:0] up_data;
  logic              all_rdy;
  logic              up_val_g;
  logic              up_rdy_a  [ND];
  logic [W-1:0]      dn_data_a [ND];
  logic              dn_sat_a  [ND];
  logic              dn_val_a  [ND];

  exp_t         exp_q [ND][$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc     = 0;
  bit           strict  = 1'b0;
  bit           done    = 1'b0;
  logic [W-1:0] hold_d  [ND];
  logic         hold_s  [ND];
  bit           held    [ND];

  // All configurations accept together so their result streams stay aligned.
  assign all_rdy  = up_rdy_a[0] & up_rdy_a[1] & up_rdy_a[2] & up_rdy_a[3];
  assign up_val_g = up_val & all_rdy;

  for (genvar i = 0; i < ND; i++) begin : g_dut
    group_add_tree #(
      .GROUP_NB  (g_of(i)),
      .NUM_WIDTH (W),
      .SATURATE  (s_of(i))
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .up_data (up_data[g_of(i)*W-1:0]),
      .up_val  (up_val_g),
      .up_rdy  (up_rdy_a[i]),
      .dn_data (dn_data_a[i]),
      .dn_sat  (dn_sat_a[i]),
      .dn_val  (dn_val_a[i]),
      .dn_rdy  (dn_rdy)
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: repeatedly pair neighbours, clamp or wrap each pairwise sum.
  function automatic logic [W:0] model(input logic [MAXG*W-1:0] v, input int n, input bit satm);
    int q[$];
    int nq[$];
    int sum;
    bit s;
    s = 1'b0;
    for (int k = 0; k < n; k++) q.push_back(int'($signed(v[k*W +: W])));
    while (q.size() > 1) begin
      nq.delete();
      for (int j = 0; j + 1 < q.size(); j += 2) begin
        sum = q[j] + q[j+1];
        if (sum > 32767 || sum < -32768) begin
          s = 1'b1;
          if (satm) sum = (sum > 0) ? 32767 : -32768;
          else      sum = ((sum + 32768) & 65535) - 32768;
        end
        nq.push_back(sum);
      end
      if (q.size() % 2 == 1) nq.push_back(q[q.size()-1]);
      q = nq;
    end
    sum = q[0];
    return {s, sum[W-1:0]};
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, i, act, exp, cyc);
    end
  endtask

  // Monitor: pops on each output transfer, checks stall stability and up_rdy.
  always @(negedge clk) begin
    exp_t e;
    logic [W:0] m;
    if (rst_n) begin
      for (int i = 0; i < ND; i++) begin
        chk("up_rdy_rule", i, up_rdy_a[i], !dn_val_a[i] || dn_rdy);
        if (held[i]) begin
          chk("stall_val", i, dn_val_a[i], 1);
          chk("stall_data", i, {dn_sat_a[i], dn_data_a[i]}, {hold_s[i], hold_d[i]});
        end
        if (dn_val_a[i] && dn_rdy) begin
          if (exp_q[i].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out dut%0d: got %0h expected no output", i, dn_data_a[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk("sum", i, {dn_sat_a[i], dn_data_a[i]}, {e.s, e.d});
            if (e.strict) chk("latency", i, cyc - e.cyc, lat_of(i));
          end
        end
        held[i]   = dn_val_a[i] && !dn_rdy;
        hold_d[i] = dn_data_a[i];
        hold_s[i] = dn_sat_a[i];
      end
      if (up_val_g) begin
        for (int i = 0; i < ND; i++) begin
          m = model(up_data, g_of(i), s_of(i));
          e.d = m[W-1:0];
          e.s = m[W];
          e.cyc = cyc;
          e.strict = strict;
          exp_q[i].push_back(e);
        end
      end
    end else begin
      for (int i = 0; i < ND; i++) held[i] = 1'b0;
    end
  end

  function automatic logic [MAXG*W-1:0] mk(input logic [W-1:0] a, b, c, d, f);
    return {f, d, c, b, a};
  endfunction

  function automatic logic [MAXG*W-1:0] rnd_vec();
    logic [MAXG*W-1:0] v;
    logic [W-1:0] x;
    for (int k = 0; k < MAXG; k++) begin
      case ($urandom_range(3))
        0: x = W'($urandom_range(64)) - 16'd32;
        1: x = 16'h7000 | W'($urandom_range(16'h0FFF));
        2: x = 16'h8000 | W'($urandom_range(16'h0FFF));
        default: x = W'($urandom);
      endcase
      v[k*W +: W] = x;
    end
    return v;
  endfunction

  // Entered #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [MAXG*W-1:0] v);
    int t;
    t = 0;
    up_data = v;
    up_val  = 1'b1;
    @(negedge clk);
    while (!all_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got up_rdy=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    up_val = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && t < 200) begin
      idle(1);
      t++;
    end
    chk("drain_pending", 0, exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst_n   = 1'b0;
    dn_rdy  = 1'b1;
    up_val  = 1'b0;
    up_data = '0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk("reset_dn_val", i, dn_val_a[i], 0);
      chk("reset_dn_data", i, dn_data_a[i], 0);
      chk("reset_dn_sat", i, dn_sat_a[i], 0);
      chk("reset_up_rdy", i, up_rdy_a[i], 1);
    end
    idle(2);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with exact-latency checking.
    strict = 1'b1;
    send(mk(16'd1, 16'd2, 16'd3, 16'd4, 16'd5));                     idle(6);
    send(mk(16'h7000, 16'h7000, 16'h0001, 16'h0000, 16'h0000));     idle(6);
    send(mk(16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000));     idle(6);
    send(mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));     idle(6);
    send(mk(16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000));     idle(6);
    strict = 1'b0;

    // Back-to-back stream of 8 with a 5-cycle downstream stall mid-stream.
    fork
      begin
        for (int n = 0; n < 8; n++) send(rnd_vec());
      end
      begin
        idle(5);
        dn_rdy = 1'b0;
        @(negedge clk);
        chk("stall_up_rdy", 0, all_rdy, 0);
        idle(4);
        dn_rdy = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random gaps and random backpressure.
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          send(rnd_vec());
          idle($urandom_range(2));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          idle(1);
          dn_rdy = ($urandom_range(3) != 0);
        end
      end
    join
    dn_rdy = 1'b1;
    drain();

    // Asynchronous reset with two results in flight and output held.
    dn_rdy = 1'b0;
    send(mk(16'd10, 16'd20, 16'd30, 16'd40, 16'd50));
    send(mk(16'd11, 16'd21, 16'd31, 16'd41, 16'd51));
    t = 0;
    while (!dn_val_a[0] && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("inflight_dn_val", 0, dn_val_a[0], 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < ND; i++) begin
      chk("async_rst_val", i, dn_val_a[i], 0);
      chk("async_rst_data", i, dn_data_a[i], 0);
      exp_q[i].delete();
    end
    idle(2);
    #2 rst_n = 1'b1;
    dn_rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < ND; i++) chk("post_rst_quiet", i, dn_val_a[i], 0);
    end
    @(posedge clk);
    #1;
    strict = 1'b1;
    send(mk(16'd100, 16'hFF9C, 16'd7, 16'd8, 16'd9));
    idle(6);
    strict = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
